// File: rtl/handshake_elastic_fifo_pkg.sv
// handshake_elastic_fifo_pkg: width helpers shared by the elastic FIFO control and storage.
package handshake_elastic_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int ptr_width(input int depth);
        return clog2(depth);
    endfunction

    // Occupancy must be able to represent DEPTH itself, hence depth+1.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage

// File: rtl/handshake_elastic_fifo_mem.sv
// handshake_elastic_fifo_mem: DEPTH x DATA_WIDTH register file, sync write, async read.
module handshake_elastic_fifo_mem
    import handshake_elastic_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// handshake_elastic_fifo: ready/valid elastic FIFO; handshakes depend on registered occupancy only.
module handshake_elastic_fifo
    import handshake_elastic_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         ins,
    input  logic                          ins_valid,
    output logic                          ins_ready,
    output logic [DATA_WIDTH-1:0]         outs,
    output logic                          outs_valid,
    input  logic                          outs_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  push, pop;

    always_comb begin
        ins_ready  = (count != CW'(DEPTH)) && !rst;
        outs_valid = (count != '0) && !rst;
        push       = ins_valid && ins_ready;
        pop        = outs_valid && outs_ready;
        outs       = outs_valid ? head : '0;
    end

    // Explicit wrap compare keeps non-power-of-two depths correct.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    handshake_elastic_fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(ins),
        .raddr(rd_ptr),
        .rdata(head)
    );

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// tb_handshake_elastic_fifo: drives a DEPTH=4 and a DEPTH=3 FIFO with shared stimulus against queue models.
module tb_handshake_elastic_fifo;

    logic        clk = 0;
    logic        rst;
    logic [35:0] ins;
    logic        ins_valid, outs_ready;
    logic        rdy_a, vld_a, rdy_b, vld_b;
    logic [35:0] outs_a, outs_b;
    logic [2:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic [35:0] qa[$];
    logic [35:0] qb[$];
    logic [35:0] fill_vals [4];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    handshake_elastic_fifo #(.DATA_WIDTH(36), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy_a),
        .outs(outs_a), .outs_valid(vld_a), .outs_ready(outs_ready), .count(cnt_a)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(36), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy_b),
        .outs(outs_b), .outs_valid(vld_b), .outs_ready(outs_ready), .count(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare both DUTs to their queue models, then advance models across one edge.
    task automatic step();
        logic [35:0] ea, eb;
        #1;
        ea = (!rst && qa.size() > 0) ? qa[0] : 36'h0;
        eb = (!rst && qb.size() > 0) ? qb[0] : 36'h0;
        chk("a_count", 64'(cnt_a), 64'(qa.size()));
        chk("a_ready", 64'(rdy_a), 64'(!rst && qa.size() < 4));
        chk("a_valid", 64'(vld_a), 64'(!rst && qa.size() > 0));
        chk("a_outs", 64'(outs_a), 64'(ea));
        chk("b_count", 64'(cnt_b), 64'(qb.size()));
        chk("b_ready", 64'(rdy_b), 64'(!rst && qb.size() < 3));
        chk("b_valid", 64'(vld_b), 64'(!rst && qb.size() > 0));
        chk("b_outs", 64'(outs_b), 64'(eb));
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            bit pa, pb;
            pa = ins_valid && qa.size() < 4;
            pb = ins_valid && qb.size() < 3;
            if (outs_ready && qa.size() > 0) void'(qa.pop_front());
            if (outs_ready && qb.size() > 0) void'(qb.pop_front());
            if (pa) qa.push_back(ins);
            if (pb) qb.push_back(ins);
        end
        @(negedge clk);
    endtask

    initial begin
        fill_vals[0] = 36'h7_0905_4E73;
        fill_vals[1] = 36'h1;
        fill_vals[2] = 36'h2;
        fill_vals[3] = 36'h3;
        rst = 1; ins = '0; ins_valid = 0; outs_ready = 0;
        @(negedge clk);
        step();
        step();
        rst = 0;
        step();
        chk("idle_ready", 64'(rdy_a), 64'd1);
        chk("idle_outs", 64'(outs_a), 64'd0);

        for (int i = 0; i < 4; i++) begin
            ins = fill_vals[i]; ins_valid = 1;
            step();
        end
        ins_valid = 0;
        #1;
        chk("fill_count", 64'(cnt_a), 64'd4);
        chk("fill_ready", 64'(rdy_a), 64'd0);
        outs_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_order", 64'(outs_a), 64'(fill_vals[i]));
            step();
        end
        chk("drain_empty", 64'(cnt_a), 64'd0);

        outs_ready = 0; ins_valid = 1;
        for (int i = 0; i < 4; i++) begin
            ins = {4'($urandom()), $urandom()};
            step();
        end
        outs_ready = 1; ins = 36'h5A5;
        step();
        chk("full_pop_count", 64'(cnt_a), 64'd3);
        chk("full_pop_ready", 64'(rdy_a), 64'd1);
        step();
        chk("full_push_count", 64'(cnt_a), 64'd3);
        ins_valid = 0;
        for (int i = 0; i < 5; i++) step();

        ins_valid = 1; outs_ready = 1;
        for (int i = 0; i < 20; i++) begin
            ins = 36'(i + 100);
            step();
            chk("stream_count", 64'(cnt_a), 64'd1);
        end
        ins_valid = 0;
        step();

        for (int i = 0; i < 400; i++) begin
            ins = {4'($urandom()), $urandom()};
            ins_valid = ($urandom_range(3, 0) != 0);
            outs_ready = ($urandom_range(2, 0) != 0);
            step();
        end

        ins_valid = 0; outs_ready = 1;
        for (int i = 0; i < 5; i++) step();
        outs_ready = 0; ins_valid = 1;
        ins = 36'h111; step();
        ins = 36'h222; step();
        chk("pre_rst_count", 64'(cnt_a), 64'd2);
        rst = 1; ins = 36'h333;
        step();
        rst = 0; ins_valid = 0;
        #1;
        chk("post_rst_count", 64'(cnt_a), 64'd0);
        chk("post_rst_valid", 64'(vld_a), 64'd0);
        ins = 36'hABC; ins_valid = 1;
        step();
        ins_valid = 0;
        #1;
        chk("post_rst_first_a", 64'(outs_a), 64'hABC);
        chk("post_rst_first_b", 64'(outs_b), 64'hABC);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/handshake_elastic_fifo.md
HANDSHAKE_ELASTIC_FIFO -- requirements
Module: handshake_elastic_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: token payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: token slots; legal range 2..64, any integer (power of two not required).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port ins, input, DATA_WIDTH: incoming token payload.
REQ-006 SHALL have port ins_valid, input, 1: producer offers a token on ins.
REQ-007 SHALL have port ins_ready, output, 1: block accepts a token this cycle.
REQ-008 SHALL have port outs, output, DATA_WIDTH: payload of the oldest stored token.
REQ-009 SHALL have port outs_valid, output, 1: a stored token is offered downstream.
REQ-010 SHALL have port outs_ready, input, 1: consumer accepts the offered token.
REQ-011 SHALL have port count, output, clog2(DEPTH+1): current occupancy, 0..DEPTH.

Function
REQ-012 SHALL perform a push when ins_valid && ins_ready at a rising edge, and a pop when outs_valid && outs_ready.
REQ-013 SHALL drive ins_ready = (count != DEPTH) && !rst, from registered state only, with no combinational path from outs_ready.
REQ-014 SHALL drive outs_valid = (count != 0) && !rst, from registered state only, with no combinational path from ins_valid or ins.
REQ-015 SHALL drive outs from the head slot when count != 0, and all-zero when count == 0.
REQ-016 SHALL deliver tokens in strict arrival order, with no loss and no duplication.
REQ-017 SHALL have a minimum latency of 1 cycle: a token pushed at edge N is offered on outs from cycle N+1.
REQ-018 SHALL sustain one push and one pop per cycle when 0 < count < DEPTH.
REQ-019 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-020 SHALL, when full, refuse a push even in a cycle where a pop occurs; ins_ready rises the cycle after the pop.
REQ-021 SHALL, when empty, not bypass ins to outs combinationally; the token is stored first.
REQ-022 SHALL wrap the read and write pointers from DEPTH-1 to 0, and SHALL handle a non-power-of-two DEPTH by explicit compare, not bit truncation.
REQ-023 SHALL hold outs and outs_valid stable while outs_valid && !outs_ready.
REQ-024 SHALL have undefined behaviour if ins changes while ins_valid && !ins_ready; the FIFO SHALL ignore ins on such cycles.

Reset
REQ-025 SHALL, with rst high at an edge, set count=0 and both pointers=0; storage contents are not reset.
REQ-026 SHALL hold ins_ready=0, outs_valid=0 and outs=0 while rst is high.
REQ-027 SHALL, on rst asserted mid-operation, discard all stored tokens, with no pop or push counted on that edge.
REQ-028 SHALL present, on the first cycle after rst deasserts, count=0, ins_ready=1 and outs_valid=0.

Structure
REQ-029 SHALL place the clog2 constant function and the pointer-width/count-width derivation in the shared handshake package; DATA_WIDTH and DEPTH stay local.
REQ-030 SHALL implement storage as one sub-module, handshake_elastic_fifo_mem: DEPTH x DATA_WIDTH registers with 1 synchronous write port and 1 asynchronous read port.
REQ-031 SHALL keep the control logic (pointers, count, ready/valid) in handshake_elastic_fifo.

Verification
REQ-032 Reset then idle: rst high for 2 cycles, then low -> count=0, ins_ready=1, outs_valid=0, outs=0.
REQ-033 Fill/drain (DATA_WIDTH=36, DEPTH=4): push 0x70905_4E73, 0x1, 0x2, 0x3 with outs_ready=0 -> count=4, ins_ready=0; then outs_ready=1 -> same 4 values in order, count reaches 0.
REQ-034 Streaming: ins_valid=1 and outs_ready=1 continuously for 20 tokens -> first token out at cycle 1, then 1 token per cycle, count stays 1.
REQ-035 Full with simultaneous pop (DEPTH=4): count=4, ins_valid=1, outs_ready=1 -> pop only, count=3; push accepted next cycle.
REQ-036 Wrap, non-power-of-two (DEPTH=3): push/pop 10 tokens with random stalls -> order preserved across pointer wrap, count never exceeds 3.
REQ-037 Mid-operation reset: count=2, assert rst for 1 cycle -> count=0, outs_valid=0; the next pushed token 0xABC is the first one out.
